vga_pattern_src: RTL

VGA_PATTERN_SRC -- requirements
Module: vga_pattern_src

---
 rtl/vga_pattern_src.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_src.sv
// ---------------------------------------------------------------------------
// vga_pattern_src
//
// Test-pattern pixel source for a VGA pipeline. The source walks a frame of
// H_ACTIVE x V_ACTIVE pixels in raster order. For every pixel the downstream
// FIFO accepts, it pushes one RGB565 word. It runs ahead of the display
// controller. The controller's end-of-frame pulse brings it back into
// alignment: the pulse starts a new frame, or aborts one that is running late.
//
// Parameters
//   H_ACTIVE      active pixels per line (>= 8, multiple of 8, <= 4096)
//   V_ACTIVE      active lines per frame (>= 1, <= 4096)
//   CHECKER_LOG2  checker square edge = 2**CHECKER_LOG2 pixels (< 12)
//
// Ports
//   clk_i         pixel clock (shared with vga_ctrl)
//   rst_i         synchronous active-high reset
//   enable_i      clock enable, same as the vga_ctrl enable
//   mode_i        pattern: 0 bars, 1 checker, 2 gradient, 3 solid grey
//   eof_i         end-of-frame pulse from vga_ctrl
//   fifo_full_i   pixel FIFO full
//   fifo_wr_en_o  pixel FIFO write strobe
//   fifo_data_o   RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   x_o, y_o      coordinates of the pixel currently presented
//   busy_o        high while a frame is being filled
//   resync_o      one-cycle pulse when eof_i aborts an unfinished frame
// ---------------------------------------------------------------------------
module vga_pattern_src #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int CHECKER_LOG2 = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [1:0]  mode_i,
    input  logic        eof_i,
    input  logic        fifo_full_i,
    output logic        fifo_wr_en_o,
    output logic [15:0] fifo_data_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        busy_o,
    output logic        resync_o
);

    localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
    localparam int          BAR_W  = H_ACTIVE / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [11:0] x_reg;
    logic [11:0] y_reg;
    logic [1:0]  mode_reg;
    logic        resync_reg;

    logic        wr;
    logic        last_px;

    assign wr      = (state_reg == FILL) && enable_i && !fifo_full_i;
    assign last_px = (x_reg == X_LAST) && (y_reg == Y_LAST);

    // ------------------------------------------------------------------
    // Frame walker
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            x_reg      <= '0;
            y_reg      <= '0;
            mode_reg   <= 2'd0;
            resync_reg <= 1'b0;
        end else begin
            resync_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable_i) begin
                        state_reg <= FILL;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        mode_reg  <= mode_i;
                    end
                end

                FILL: begin
                    if (enable_i && eof_i) begin
                        // The controller has started a new frame. Any write in
                        // this cycle still happens. Restart at the origin.
                        // This counts as a resync only if that write did not
                        // already complete the frame.
                        state_reg  <= FILL;
                        x_reg      <= '0;
                        y_reg      <= '0;
                        mode_reg   <= mode_i;
                        resync_reg <= !(wr && last_px);
                    end else if (wr) begin
                        if (last_px) begin
                            state_reg <= DONE;
                        end else if (x_reg == X_LAST) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 12'd1;
                        end else begin
                            x_reg <= x_reg + 12'd1;
                        end
                    end
                end

                DONE: begin
                    if (enable_i && eof_i) begin
                        state_reg <= FILL;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        mode_reg  <= mode_i;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    x_reg     <= '0;
                    y_reg     <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Colour bars: the bar index is the count of thresholds that x has
    // passed. The thresholds are the constant multiples of the bar width,
    // so no divider is needed.
    // ------------------------------------------------------------------
    logic [6:0] bar_ge;
    logic [2:0] bar_idx;
    logic [15:0] bar_pix;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_bar_thr
            assign bar_ge[gi] = ({1'b0, x_reg} >= 13'((gi + 1) * BAR_W));
        end
    endgenerate

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + 3'(bar_ge[i]);
        end
    end

    always_comb begin
        case (bar_idx)
            3'd0:    bar_pix = 16'hFFFF;  // white
            3'd1:    bar_pix = 16'hFFE0;  // yellow
            3'd2:    bar_pix = 16'h07FF;  // cyan
            3'd3:    bar_pix = 16'h07E0;  // green
            3'd4:    bar_pix = 16'hF81F;  // magenta
            3'd5:    bar_pix = 16'hF800;  // red
            3'd6:    bar_pix = 16'h001F;  // blue
            default: bar_pix = 16'h0000;  // black
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern mux. The pixel depends only on the registered state, so it
    // is valid in the same cycle as the write strobe.
    // ------------------------------------------------------------------
    logic checker_bit;
    assign checker_bit = x_reg[CHECKER_LOG2] ^ y_reg[CHECKER_LOG2];

    always_comb begin
        case (mode_reg)
            2'd0:    fifo_data_o = bar_pix;
            2'd1:    fifo_data_o = checker_bit ? 16'hFFFF : 16'h0000;
            2'd2:    fifo_data_o = {x_reg[7:3], y_reg[7:2], ~x_reg[7:3]};
            default: fifo_data_o = 16'h8410;
        endcase
    end

    assign fifo_wr_en_o = wr;
    assign x_o          = x_reg;
    assign y_o          = y_reg;
    assign busy_o       = (state_reg == FILL);
    assign resync_o     = resync_reg;

endmodule
